// File: rtl/sram_like_bridge_if.sv
// ----------------------------------------------------------------------------
// sram_like_bridge_if
// Purpose : SRAM-like bus bundle between a memory-port bridge and the
//           bus/cache side (request phase, then data phase).
// Signals :
//   bus_req      bridge -> bus   request valid
//   bus_wr       bridge -> bus   1 = write, 0 = read
//   bus_size     bridge -> bus   log2 of bytes transferred
//   bus_addr     bridge -> bus   byte address
//   bus_wdata    bridge -> bus   write data
//   bus_addr_ok  bus -> bridge   request accepted
//   bus_data_ok  bus -> bridge   data phase complete, bus_rdata valid
//   bus_rdata    bus -> bridge   read data
// Modports: master (bridge side), slave (bus/cache side).
// ----------------------------------------------------------------------------
interface sram_like_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              bus_req;
    logic              bus_wr;
    logic [2:0]        bus_size;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/sram_like_bridge.sv
// ----------------------------------------------------------------------------
// sram_like_bridge
// Purpose : Converts a pipeline stage's single-cycle SRAM port into one
//           transaction on a handshaked SRAM-like bus, stalling the stage
//           while the transaction is outstanding and holding the returned
//           read data while the pipeline is frozen by another source.
// Ports   :
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   cpu_en              access request from the pipeline stage
//   cpu_wen [BE_W]      byte write enables, all zero = read
//   cpu_addr/cpu_wdata  access address / store data
//   cpu_rdata           load data to the pipeline
//   cpu_stall           access not yet complete
//   pipe_stall          pipeline hold from other sources
//   bus                 sram_like_bridge_if.master bus port
// Build option:
//   SRAM_LIKE_BRIDGE_RDATA_BYPASS_EN  defined  -> read data and stall release
//       are forwarded combinationally in the completion cycle.
//   undefined (default)                        -> completion goes through a
//       one-cycle RESP state; cpu_rdata is purely registered.
// DATA_W must be 32, 64 or 128.
// ----------------------------------------------------------------------------
module sram_like_bridge #(
    parameter int  ADDR_W = 32,
    parameter int  DATA_W = 32,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic [BE_W-1:0]   cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              pipe_stall,
    sram_like_bridge_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        RESP,
        DONE
    } stateEnum;

    stateEnum          state;
    stateEnum          doneNext;
    logic              wrReg;
    logic [2:0]        sizeReg;
    logic [ADDR_W-1:0] addrReg;
    logic [DATA_W-1:0] wdataReg;
    logic [DATA_W-1:0] rdataReg;
    logic              completion;
    logic              inFlight;

    // Transfer size: full width for reads, otherwise the number of enabled
    // bytes rounded up to the next power of two (odd patterns are a caller
    // error, rounding up keeps every enabled lane inside the transfer).
    function automatic logic [2:0] sizeOf(input logic [BE_W-1:0] wen);
        int         cnt;
        logic [2:0] s;
        cnt = 0;
        for (int i = 0; i < BE_W; i++) begin
            cnt = cnt + int'(wen[i]);
        end
        if (cnt == 0) begin
            cnt = BE_W;
        end
        s = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if ((1 << i) < cnt) begin
                s = 3'(i + 1);
            end
        end
        return s;
    endfunction

    // A data_ok is only meaningful once the request has been accepted:
    // either together with addr_ok, or any time later in DATA.
    assign completion = ((state == ADDR) && bus.bus_addr_ok && bus.bus_data_ok) ||
                        ((state == DATA) && bus.bus_data_ok);
    assign inFlight   = (state == ADDR) || (state == DATA);

`ifdef SRAM_LIKE_BRIDGE_RDATA_BYPASS_EN
    assign doneNext  = pipe_stall ? DONE : IDLE;
    // Stall releases in the completion cycle itself; rst gating keeps every
    // output at zero while reset is applied even if cpu_en is high.
    assign cpu_stall = !rst && (((state == IDLE) && cpu_en) || (inFlight && !completion));
    assign cpu_rdata = completion ? bus.bus_rdata : rdataReg;
`else
    assign doneNext  = RESP;
    assign cpu_stall = !rst && (((state == IDLE) && cpu_en) || inFlight);
    assign cpu_rdata = rdataReg;
`endif

    // Request is decoded from state only, so it drops the instant rst hits.
    assign bus.bus_req   = (state == ADDR);
    assign bus.bus_wr    = wrReg;
    assign bus.bus_size  = sizeReg;
    assign bus.bus_addr  = addrReg;
    assign bus.bus_wdata = wdataReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wrReg    <= 1'b0;
            sizeReg  <= 3'd0;
            addrReg  <= '0;
            wdataReg <= '0;
            rdataReg <= '0;
        end else if (completion) begin
            if (!wrReg) begin
                rdataReg <= bus.bus_rdata;
            end
            state <= doneNext;
        end else begin
            case (state)
                IDLE: begin
                    // Issued even under pipe_stall: the bus latency then
                    // overlaps the external hold.
                    if (cpu_en) begin
                        wrReg    <= |cpu_wen;
                        sizeReg  <= sizeOf(cpu_wen);
                        addrReg  <= cpu_addr;
                        wdataReg <= cpu_wdata;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.bus_addr_ok) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    state <= DATA;
                end
                RESP: begin
                    state <= pipe_stall ? DONE : IDLE;
                end
                DONE: begin
                    if (!pipe_stall) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_like_bridge.sv
`timescale 1ns/1ps
module tb_sram_like_bridge;

`ifdef SRAM_LIKE_BRIDGE_RDATA_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        cpuEn;
    logic [3:0]  cpuWen;
    logic [31:0] cpuAddr, cpuWdata, cpuRdata;
    logic        cpuStall, pipeStall;
    sram_like_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus32 ();
    sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .cpu_en(cpuEn), .cpu_wen(cpuWen), .cpu_addr(cpuAddr),
        .cpu_wdata(cpuWdata), .cpu_rdata(cpuRdata), .cpu_stall(cpuStall),
        .pipe_stall(pipeStall), .bus(bus32)
    );

    // 64-bit instance
    logic        en64;
    logic [7:0]  wen64;
    logic [31:0] addr64;
    logic [63:0] wdata64, rdata64;
    logic        stall64, pstall64;
    sram_like_bridge_if #(.ADDR_W(32), .DATA_W(64)) bus64 ();
    sram_like_bridge #(.ADDR_W(32), .DATA_W(64)) dut64 (
        .clk(clk), .rst(rst), .cpu_en(en64), .cpu_wen(wen64), .cpu_addr(addr64),
        .cpu_wdata(wdata64), .cpu_rdata(rdata64), .cpu_stall(stall64),
        .pipe_stall(pstall64), .bus(bus64)
    );

    int nVec = 0;
    int nBad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nVec++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expectations for the current cycle, filled in by the driver.
    bit          expValid = 1'b0;
    logic        expReq, expStall, expWr;
    logic [2:0]  expSize;
    logic [31:0] expRdata, expAddr, expWdata;
    logic [31:0] lastRd = 32'h0;   // model of the last completed read

    always @(negedge clk) begin
        if (expValid) begin
            chk("bus_req", bus32.bus_req, expReq);
            chk("cpu_stall", cpuStall, expStall);
            chk("cpu_rdata", cpuRdata, expRdata);
            if (expReq) begin
                chk("bus_wr", bus32.bus_wr, expWr);
                chk("bus_size", bus32.bus_size, expSize);
                chk("bus_addr", bus32.bus_addr, expAddr);
                chk("bus_wdata", bus32.bus_wdata, expWdata);
            end
        end
    end

    // Size rule: full width on reads, else enabled bytes rounded up to 2^n.
    function automatic logic [2:0] sizeRule(input int ones, input int beW);
        int n, s;
        n = (ones == 0) ? beW : ones;
        s = 0;
        while ((1 << s) < n) s++;
        return 3'(s);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observations from the last transaction (used for literal pins).
    int          reqCycles, firstLow, lowCycles;
    logic [2:0]  sawSize;
    logic        sawWr;
    logic [31:0] sawAddr;

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cpuEn = 1'b0; cpuWen = $urandom; cpuAddr = $urandom; cpuWdata = $urandom;
            pipeStall = $urandom_range(0, 1);
            bus32.bus_addr_ok = 1'b0; bus32.bus_data_ok = 1'b0; bus32.bus_rdata = $urandom;
            expReq = 1'b0; expStall = 1'b0; expRdata = lastRd;
            step();
        end
    endtask

    // One complete access.  Timeline in cycles from cpu_en (k=0):
    // ADDR occupies 1..1+A (addr_ok at 1+A); completion C is 1+A when
    // data_ok comes with addr_ok, else 2+A+D. The stage sees stall low from
    // Rl (C, or C+1 without bypass) and holds for H cycles of pipe_stall.
    task automatic runTxn(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int A, input bit same, input int D,
                          input int H);
        int  c, rl, last;
        bit  isRd;
        c    = same ? 1 + A : 2 + A + D;
        rl   = c + (BYPASS ? 0 : 1);
        last = rl + H;
        isRd = (wen == 4'd0);
        reqCycles = 0; firstLow = -1; lowCycles = 0;
        for (int k = 0; k <= last; k++) begin
            cpuEn = 1'b1;
            if (k == 0) begin
                cpuWen = wen; cpuAddr = addr; cpuWdata = wdata;
            end else begin
                cpuWen = $urandom; cpuAddr = $urandom; cpuWdata = $urandom;
            end
            if (k < rl)        pipeStall = $urandom_range(0, 1);
            else if (k < last) pipeStall = 1'b1;
            else               pipeStall = 1'b0;
            bus32.bus_addr_ok = (k == 1 + A);
            bus32.bus_data_ok = (k == c) || (k >= 1 && k < 1 + A && $urandom_range(0, 1) == 1);
            bus32.bus_rdata   = (k == c) ? rdata : $urandom;

            expReq   = (k >= 1) && (k <= 1 + A);
            expStall = (k < rl);
            expWr    = !isRd;
            expSize  = sizeRule($countones(wen), 4);
            expAddr  = addr;
            expWdata = wdata;
            if (BYPASS && k == c) expRdata = bus32.bus_rdata;
            else                  expRdata = lastRd;
            if (k == c && isRd) lastRd = rdata;

            @(negedge clk);
            if (bus32.bus_req === 1'b1) begin
                reqCycles++;
                sawSize = bus32.bus_size; sawWr = bus32.bus_wr; sawAddr = bus32.bus_addr;
            end
            if (cpuStall === 1'b0) begin
                lowCycles++;
                if (firstLow < 0) firstLow = k;
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        cpuEn = 0; cpuWen = 0; cpuAddr = 0; cpuWdata = 0; pipeStall = 0;
        bus32.bus_addr_ok = 0; bus32.bus_data_ok = 0; bus32.bus_rdata = 0;
        en64 = 0; wen64 = 0; addr64 = 0; wdata64 = 0; pstall64 = 0;
        bus64.bus_addr_ok = 0; bus64.bus_data_ok = 0; bus64.bus_rdata = 0;
        #12;
        chk("reset bus_req", bus32.bus_req, 1'b0);
        chk("reset cpu_stall", cpuStall, 1'b0);
        chk("reset cpu_rdata", cpuRdata, 32'h0);
        chk("reset bus_addr", bus32.bus_addr, 32'h0);
        chk("reset bus_size", bus32.bus_size, 3'd0);
        @(negedge clk); rst = 1'b0;
        step();
        expValid = 1'b1;
        idle(2);

        // Read, addr_ok then data_ok next cycle
        runTxn(4'b0000, 32'hBFC00000, 32'h0, 32'h3C1D0001, 0, 1'b0, 0, 0);
        chk("rd size", sawSize, 3'd2);
        chk("rd wr", sawWr, 1'b0);
        chk("rd req cycles", reqCycles, 1);
        chk("rd first stall low", firstLow, BYPASS ? 2 : 3);
        chk("rd data", cpuRdata, 32'h3C1D0001);
        idle(1);

        // Byte store, addr_ok and data_ok together
        runTxn(4'b0100, 32'h80000002, 32'h00AB0000, 32'hDEADBEEF, 0, 1'b1, 0, 0);
        chk("sb wr", sawWr, 1'b1);
        chk("sb size", sawSize, 3'd0);
        chk("sb req cycles", reqCycles, 1);
        chk("sb first stall low", firstLow, BYPASS ? 1 : 2);
        idle(1);
        chk("sb keeps rdata", cpuRdata, 32'h3C1D0001);

        // addr_ok delayed 3 cycles, cpu_addr wandering meanwhile
        runTxn(4'b0000, 32'h00001000, 32'h0, 32'hCAFEF00D, 3, 1'b0, 1, 0);
        chk("slow req cycles", reqCycles, 4);
        chk("slow bus_addr", sawAddr, 32'h00001000);
        idle(1);

        // pipe_stall held 5 cycles after completion
        runTxn(4'b0000, 32'h00002000, 32'h0, 32'h12345678, 1, 1'b0, 2, 5);
        chk("hold low cycles", lowCycles, 6);
        chk("hold rdata", cpuRdata, 32'h12345678);
        idle(2);

        // Reset in DATA
        expValid = 1'b0;
        cpuEn = 1; cpuWen = 0; cpuAddr = 32'h10000040; pipeStall = 0;
        step();
        cpuEn = 1; bus32.bus_addr_ok = 1; bus32.bus_data_ok = 0;
        step();
        bus32.bus_addr_ok = 0; bus32.bus_data_ok = 0;
        #1;
        chk("pre-rst stall", cpuStall, 1'b1);
        #1; rst = 1'b1; #1;
        chk("rst bus_req", bus32.bus_req, 1'b0);
        chk("rst cpu_stall", cpuStall, 1'b0);
        chk("rst cpu_rdata", cpuRdata, 32'h0);
        chk("rst bus_addr", bus32.bus_addr, 32'h0);
        chk("rst bus_wdata", bus32.bus_wdata, 32'h0);
        @(negedge clk); rst = 1'b0; cpuEn = 1'b0;
        lastRd = 32'h0;
        step();
        expValid = 1'b1;
        runTxn(4'b0000, 32'h10000040, 32'h0, 32'h0BADC0DE, 1, 1'b0, 0, 1);
        chk("post-rst rdata", cpuRdata, 32'h0BADC0DE);

        // Randomised traffic against the timeline model
        for (int t = 0; t < 250; t++) begin
            logic [3:0] w;
            w = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 15));
            runTxn(w, $urandom, $urandom, $urandom, $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), $urandom_range(0, 2),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(1);
        expValid = 1'b0;

        // 64-bit instance: full-width store and read both give size 3
        en64 = 1; wen64 = 8'hFF; addr64 = 32'h100; wdata64 = 64'h0123456789ABCDEF;
        step();
        chk("w64 req", bus64.bus_req, 1'b1);
        chk("w64 wr", bus64.bus_wr, 1'b1);
        chk("w64 size", bus64.bus_size, 3'd3);
        en64 = 0; bus64.bus_addr_ok = 1; bus64.bus_data_ok = 1;
        step();
        bus64.bus_addr_ok = 0; bus64.bus_data_ok = 0;
        step(); step();
        en64 = 1; wen64 = 8'h00; addr64 = 32'h108;
        step();
        chk("r64 req", bus64.bus_req, 1'b1);
        chk("r64 wr", bus64.bus_wr, 1'b0);
        chk("r64 size", bus64.bus_size, 3'd3);
        en64 = 0; bus64.bus_addr_ok = 1; bus64.bus_data_ok = 1;
        bus64.bus_rdata = 64'hFEDCBA9876543210;
        step();
        bus64.bus_addr_ok = 0; bus64.bus_data_ok = 0;
        step(); step();
        chk("r64 data", rdata64, 64'hFEDCBA9876543210);
        chk("r64 stall", stall64, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule

// File: doc/sram_like_bridge.md
Name: sram_like_bridge

Overview:
- Parametrised memory-port bridge between a pipeline stage's single-cycle SRAM-style port (en/wen/addr/wdata/rdata) and a handshaked SRAM-like bus (req/addr_ok/data_ok).
- One instance is placed per channel, instruction and data, between the core datapath and the bus/cache interface.
- Generates a stall to the pipeline while a transaction is outstanding.
- Buffers the returned read data while the pipeline is held by another source.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be 32, 64 or 128.
- BE_W, DATA_W/8, byte-enable width; derived, do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_en  in  1  access request from the pipeline stage.
- cpu_wen  in  BE_W  byte write enables; all zero means read.
- cpu_addr  in  ADDR_W  access address.
- cpu_wdata  in  DATA_W  store data.
- cpu_rdata  out  DATA_W  load data returned to the pipeline.
- cpu_stall  out  1  high while the access is not yet complete.
- pipe_stall  in  1  global pipeline hold from other sources; the stage does not advance while high.
- bus_req  out  1  bus request.
- bus_wr  out  1  1 = write, 0 = read.
- bus_size  out  3  log2 of the number of bytes transferred.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_addr_ok  in  1  request accepted.
- bus_data_ok  in  1  data phase complete; bus_rdata is valid in this cycle.
- bus_rdata  in  DATA_W  bus read data.

Behaviour:
- Reset values: all outputs 0; state IDLE; request and rdata registers cleared.
- FSM states:
  - IDLE: cpu_en=1 -> capture wr/size/addr/wdata, go to ADDR.
  - ADDR: bus_req=1 and the captured fields drive the bus.
    - bus_addr_ok=1 and bus_data_ok=0 -> DATA.
    - bus_addr_ok=1 and bus_data_ok=1 in the same cycle -> completion.
    - bus_data_ok without bus_addr_ok is ignored.
  - DATA: bus_req=0.
    - bus_data_ok=1 -> completion: latch bus_rdata into the rdata register (reads only; writes leave it unchanged).
    - After completion: pipe_stall=0 -> IDLE, pipe_stall=1 -> DONE.
  - DONE: result held; cpu_stall=0. Go to IDLE on the first cycle pipe_stall=0.
- bus_req is a pure function of state; the captured request fields stay stable from ADDR entry until bus_addr_ok.
- cpu_stall:
  - Combinationally high when (state IDLE and cpu_en) or state ADDR or state DATA.
  - Deasserts in the completion cycle (bypass build) or in the cycle after completion (non-bypass build, see Optional Feature).
- bus_size:
  - Read: log2(BE_W).
  - Write: log2(popcount(cpu_wen)).
  - Non-power-of-two or misaligned wen patterns are a caller error; the bridge drives the size of the next power of two.
- bus_addr equals cpu_addr unmodified; alignment is the caller's responsibility.
- cpu_rdata: the rdata register outside completion cycles, so it stays valid through DONE.
- The bridge never issues a second request before the first completes; at most one transaction is outstanding.
- A change of cpu_en/cpu_addr while in ADDR or DATA is ignored; the captured request is used.
- Reset mid-transaction: async return to IDLE, bus_req drops immediately; the bus side is reset by the same rst.
- cpu_en=1 in IDLE with pipe_stall=1: the request is still issued.

Optional Feature:
- SRAM_LIKE_BRIDGE_RDATA_BYPASS_EN defined:
  - In the completion cycle, cpu_rdata = bus_rdata combinationally and cpu_stall=0.
  - Access latency = bus latency.
- Not defined:
  - Completion moves to a one-cycle RESP state: cpu_stall=1 in the completion cycle, 0 in RESP.
  - cpu_rdata comes only from the register; no combinational path from the bus to the pipeline.
  - RESP goes to IDLE or DONE by pipe_stall, with the same rule as completion.

Test Plan:
- Read, addr_ok and data_ok one cycle apart:
  - cpu_en=1, wen=0, addr=0xBFC00000.
  - Expect bus_req=1, bus_wr=0, bus_size=2.
  - bus_rdata=0x3C1D0001 -> cpu_rdata=0x3C1D0001.
  - cpu_stall low in the data_ok cycle (bypass build) or the next cycle (non-bypass build).
- Byte store, addr_ok and data_ok in the same cycle:
  - wen=4'b0100, addr=0x80000002, wdata=0x00AB0000.
  - Expect bus_wr=1, bus_size=0, a single-cycle bus_req, return to IDLE.
- addr_ok delayed 3 cycles:
  - bus_req and bus_addr stay stable for 4 cycles.
  - cpu_stall stays high throughout; changing cpu_addr mid-wait does not alter bus_addr.
- pipe_stall held 5 cycles after data_ok with rdata=0x12345678:
  - FSM holds DONE, cpu_stall=0, cpu_rdata stays 0x12345678.
  - FSM returns to IDLE the cycle after pipe_stall falls.
- rst pulsed while in DATA:
  - All outputs go to 0 immediately; after release, a new read issues normally.
- DATA_W=64, wen=8'hFF:
  - Expect bus_size=3; a 64-bit read with wen=0 also gives bus_size=3.
